conv_output_axis_streamer: RTL and testbench
============================================

// Module: conv_output_axis_streamer
// PURPOSE
//   Drains one finished output row from the conv output BRAM (port B) and emits it as an
//   AXI4-Stream master with full tready backpressure. Sits directly downstream of the PE
//   output-buffer control. Rescales each ACC_W accumulator to DATA_W with round + saturate.
//   Asserts tlast on the final word of the final row of a frame.
// PARAMETERS
//   ACC_W      32   width of an output-BRAM word (signed accumulator)
//   DATA_W     16   width of m_axis_tdata (signed, saturated)
//   ADDR_W     15   output-BRAM port-B address width
//   ROW_LEN    256  words per row, 1..2^ADDR_W
//   FRAC_SHIFT 8    arithmetic right shift applied before saturation, 0..ACC_W-1
//   FIFO_DEPTH 4    output skid FIFO depth, power of 2, >=4
// PORTS
//   clk            in   1       clock
//   Reset          in   1       asynchronous reset, active-low
//   row_start      in   1       pulse: row in BRAM is complete, begin drain
//   row_last       in   1       sampled with row_start: this is the frame's last row
//   busy           out  1       high from accepted row_start until row_done
//   row_done       out  1       1-cycle pulse: last word of row accepted downstream
//   enb_output_BRAM out 1       port-B read enable
//   addrb          out  ADDR_W  port-B read address
//   doutb          in   ACC_W   port-B read data, valid 1 cycle after enb
//   m_axis_tdata   out  DATA_W  stream data
//   m_axis_tvalid  out  1       stream valid
//   m_axis_tready  in   1       stream ready
//   m_axis_tlast   out  1       end of frame
// BEHAVIOUR
//   Reset (async, Reset=0): state IDLE; all outputs 0; addrb=0; FIFO empty; in-flight flag
//     cleared; last-row flag cleared. Takes effect mid-row immediately; partial row is dropped.
//   FSM: IDLE -> READ on row_start (latch row_last, addrb=0). row_start while busy is ignored.
//     READ: issue read (enb=1, addrb++) when fifo_count+inflight < FIFO_DEPTH. After issuing
//       addr ROW_LEN-1 -> DRAIN.
//     DRAIN: no reads. When the last word of the row handshakes -> DONE.
//     DONE: row_done=1 for one cycle, busy=0, -> IDLE. A row_start in DONE is ignored.
//   busy=1 in READ/DRAIN/DONE except DONE deasserts busy; row_done only in DONE.
//   BRAM latency is exactly 1: inflight<=enb. doutb is pushed into the FIFO the next cycle,
//     rescaled. Push and pop in the same cycle keep fifo_count unchanged.
//   Rescale: r = (doutb + (FRAC_SHIFT>0 ? 1<<(FRAC_SHIFT-1) : 0)) >>> FRAC_SHIFT.
//     The sum is computed in ACC_W+1 bits. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//   AXI: m_axis_tvalid = FIFO non-empty. Pop on tvalid&tready. tdata and tlast stay stable
//     while tvalid=1 and tready=0.
//   Throughput: with tready held 1, one word per cycle after 2-cycle fill latency
//     (row_start at cycle 0 -> first read issued cycle 1 -> first tvalid cycle 3).
//   tlast: stored per FIFO entry. Set only for word index ROW_LEN-1 when latched row_last=1.
//   Word counter: counts pops, 0..ROW_LEN-1. Pop at ROW_LEN-1 ends the row.
//   addrb does not wrap into the next row; it is reset to 0 on each accepted row_start.
//   ROW_LEN=1: single read, DRAIN immediately, row_done after the single pop.
// TESTING
//   T1 ROW_LEN=8, tready=1, BRAM[i]=i<<8, row_last=0 -> tdata 0..7 on consecutive cycles,
//      tlast never set, row_done pulses the cycle after word 7.
//   T2 same row, row_last=1 -> tlast=1 only with tdata=7. busy falls with row_done.
//   T3 tready toggles 1,0,0,1 repeatedly -> no word lost or duplicated. tdata is stable
//      while stalled. FIFO never overflows (fifo_count<=4). Reads pause when full.
//   T4 rescale: BRAM = 0x7FFFFFFF -> 0x7FFF. 0x80000000 -> 0x8000. 0x00000180 -> 0x0002.
//      0xFFFFFF7F -> 0xFFFF. 0x0000007F -> 0x0000.
//   T5 row_start pulsed again mid-row -> ignored. The row completes with exactly ROW_LEN words.
//   T6 Reset=0 asserted mid-row with tvalid=1 -> tvalid=0 immediately. After release, a new
//      row_start streams the full row from address 0.

Source files
------------

// File: rtl/conv_output_axis_streamer.sv
// Output-row drainer: BRAM port B -> rescale/saturate -> skid FIFO -> AXI4-Stream.
// Reads are credit-limited so the FIFO can absorb every in-flight word under backpressure.
module conv_output_axis_streamer #(
  parameter int ACC_W      = 32,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 15,
  parameter int ROW_LEN    = 256,
  parameter int FRAC_SHIFT = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              row_start,
  input  logic              row_last,
  output logic              busy,
  output logic              row_done,
  output logic              enb_output_BRAM,
  output logic [ADDR_W-1:0] addrb,
  input  logic [ACC_W-1:0]  doutb,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_LEN - 1);
  localparam logic signed [ACC_W:0] RND =
    (ACC_W+1)'((1 << FRAC_SHIFT) >> 1);
  localparam logic signed [ACC_W:0] SMAX =
    {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN =
    {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_pop_idx;
  logic              r_row_last;
  logic              r_busy;
  logic              r_row_done;
  logic              r_inflight;
  logic              r_infl_last;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];

  logic                    w_issue;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_last_pop;
  logic [CW:0]             w_credit;
  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W:0]   w_shf;
  logic [DATA_W-1:0]       w_sat;

  // Issue a read only when FIFO space covers every word already requested.
  always_comb begin
    w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    w_issue  = (r_state == S_READ) && (w_credit < (CW+1)'(FIFO_DEPTH));
    w_push   = r_inflight;
    w_pop    = m_axis_tvalid & m_axis_tready;
    w_last_pop = w_pop && (r_pop_idx == LAST_ADDR);
  end

  // Round half-up, arithmetic shift, then clamp to the signed output range.
  always_comb begin
    w_sum = $signed({doutb[ACC_W-1], doutb}) + RND;
    w_shf = w_sum >>> FRAC_SHIFT;
    if (w_shf > SMAX)
      w_sat = SMAX[DATA_W-1:0];
    else if (w_shf < SMIN)
      w_sat = SMIN[DATA_W-1:0];
    else
      w_sat = w_shf[DATA_W-1:0];
  end

  // Row sequencer: accept a row, walk read addresses, count pops, signal done.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_pop_idx  <= '0;
      r_row_last <= 1'b0;
      r_busy     <= 1'b0;
      r_row_done <= 1'b0;
    end else begin
      r_row_done <= 1'b0;
      if (w_pop)
        r_pop_idx <= w_last_pop ? '0 : r_pop_idx + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (row_start) begin
            r_state    <= S_READ;
            r_addr     <= '0;
            r_pop_idx  <= '0;
            r_row_last <= row_last;
            r_busy     <= 1'b1;
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (r_addr == LAST_ADDR)
              r_state <= S_DRAIN;
            else
              r_addr <= r_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_last_pop) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_row_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // One-cycle BRAM latency tracker, tagging the row's final word.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_inflight  <= w_issue;
      r_infl_last <= w_issue && (r_addr == LAST_ADDR);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop)
        r_count <= r_count - 1'b1;
    end
  end

  // FIFO storage: rescaled word plus its end-of-frame flag.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_sat;
      r_mem_last[r_wr_ptr] <= r_infl_last & r_row_last;
    end
  end

  assign m_axis_tvalid   = (r_count != '0);
  assign m_axis_tdata    = m_axis_tvalid ? r_mem_data[r_rd_ptr] : '0;
  assign m_axis_tlast    = m_axis_tvalid & r_mem_last[r_rd_ptr];
  assign enb_output_BRAM = w_issue;
  assign addrb           = r_addr;
  assign busy            = r_busy;
  assign row_done        = r_row_done;

endmodule

// File: tb/tb_conv_output_axis_streamer.sv
// Scoreboard bench for conv_output_axis_streamer with an 8-word row.
// Stimulus queues expected words; a negedge monitor pops and compares.
module tb_conv_output_axis_streamer;

  localparam int RL = 8;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        row_start = 1'b0;
  logic        row_last = 1'b0;
  logic        busy;
  logic        row_done;
  logic        enb;
  logic [14:0] addrb;
  logic [31:0] doutb = '0;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        tlast;

  conv_output_axis_streamer #(
    .ACC_W(32), .DATA_W(16), .ADDR_W(15),
    .ROW_LEN(RL), .FRAC_SHIFT(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .row_start(row_start),
    .row_last(row_last),
    .busy(busy),
    .row_done(row_done),
    .enb_output_BRAM(enb),
    .addrb(addrb),
    .doutb(doutb),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast(tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
    logic        e;
  } exp_t;

  exp_t        q[$];
  logic [31:0] bram [RL];
  logic [15:0] expd [RL];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int c0 = 0;
  int first_v = -1;
  bit seen_v = 1'b0;
  int eor_cyc = -100;
  int done_cnt = 0;
  int issued = 0;
  int popped = 0;
  int max_out = 0;
  bit stall = 1'b0;
  logic [16:0] held = '0;

  always @(posedge clk) cyc++;

  always @(posedge clk)
    if (enb) doutb <= bram[addrb[2:0]];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: handshakes, stall stability, credit bound, row_done timing.
  always @(negedge clk) begin
    exp_t it;
    if (Reset) begin
      if (enb) issued++;
      if (issued - popped > max_out) max_out = issued - popped;
      if (tvalid && !seen_v) begin
        seen_v = 1'b1;
        first_v = cyc;
      end
      if (stall && tvalid)
        chk("stall_stable", {15'd0, tlast, tdata}, {15'd0, held});
      stall = tvalid && !tready;
      held = {tlast, tdata};
      if (tvalid && tready) begin
        popped++;
        if (q.size() == 0) begin
          chk("unexpected_word", {16'd0, tdata}, 32'hDEAD);
        end else begin
          it = q.pop_front();
          chk("tdata", {16'd0, tdata}, {16'd0, it.d});
          chk("tlast", {31'd0, tlast}, {31'd0, it.l});
          if (it.e) eor_cyc = cyc;
        end
      end
      if (row_done) begin
        done_cnt++;
        chk("done_timing", cyc, eor_cyc + 1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic start_row(input bit last);
    for (int i = 0; i < RL; i++) begin
      exp_t e;
      e.d = expd[i];
      e.l = last && (i == RL - 1);
      e.e = (i == RL - 1);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    row_start = 1'b1;
    row_last = last;
    c0 = cyc;
    seen_v = 1'b0;
    @(posedge clk);
    #1;
    row_start = 1'b0;
    row_last = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int k = 0; k < budget && done_cnt < target; k++)
      @(posedge clk);
    #1;
    chk("row_done_count", done_cnt, target);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < RL; i++) begin
      bram[i] = 32'(i) << 8;
      expd[i] = 16'(i);
    end
  endtask

  initial begin
    int d0;
    set_ramp();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, row_done}, 32'd0);
    chk("rst_enb", {31'd0, enb}, 32'd0);
    chk("rst_addrb", {17'd0, addrb}, 32'd0);
    chk("rst_tlast", {31'd0, tlast}, 32'd0);
    chk("rst_tdata", {16'd0, tdata}, 32'd0);
    Reset = 1'b1;

    // T1: ramp, tready=1, not last row.
    tready = 1'b1;
    d0 = done_cnt;
    start_row(1'b0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(d0 + 1, 60);
    chk("t1_first_valid", first_v, c0 + 3);
    chk("t1_last_word", eor_cyc, c0 + 3 + RL - 1);

    // T2: same row flagged as frame end.
    d0 = done_cnt;
    start_row(1'b1);
    wait_done(d0 + 1, 60);

    // T3: backpressure pattern 1,0,0,1.
    d0 = done_cnt;
    issued = 0;
    popped = 0;
    max_out = 0;
    start_row(1'b0);
    for (int k = 0; k < 48; k++) begin
      tready = (k % 4 == 0) || (k % 4 == 3);
      @(posedge clk);
      #1;
    end
    tready = 1'b1;
    wait_done(d0 + 1, 60);
    chk("t3_max_outstanding", max_out, 4);

    // T4: rescale and saturation corners, last row.
    bram[0] = 32'h7FFFFFFF; expd[0] = 16'h7FFF;
    bram[1] = 32'h80000000; expd[1] = 16'h8000;
    bram[2] = 32'h00000180; expd[2] = 16'h0002;
    bram[3] = 32'hFFFFFF7F; expd[3] = 16'hFFFF;
    bram[4] = 32'h0000007F; expd[4] = 16'h0000;
    bram[5] = 32'h00012345; expd[5] = 16'h0123;
    bram[6] = 32'hFFFF0000; expd[6] = 16'hFF00;
    bram[7] = 32'h00000080; expd[7] = 16'h0001;
    d0 = done_cnt;
    start_row(1'b1);
    wait_done(d0 + 1, 60);

    // T5: stray row_start mid-row is ignored.
    set_ramp();
    d0 = done_cnt;
    start_row(1'b0);
    repeat (2) @(posedge clk);
    #1;
    row_start = 1'b1;
    row_last = 1'b1;
    @(posedge clk);
    #1;
    row_start = 1'b0;
    row_last = 1'b0;
    wait_done(d0 + 1, 60);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_single_done", done_cnt, d0 + 1);
    chk("t5_idle_tvalid", {31'd0, tvalid}, 32'd0);

    // T6: reset mid-row with tvalid high.
    tready = 1'b0;
    start_row(1'b0);
    for (int k = 0; k < 10 && !tvalid; k++) begin
      @(posedge clk);
      #1;
    end
    chk("t6_tvalid_before", {31'd0, tvalid}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("t6_tvalid_rst", {31'd0, tvalid}, 32'd0);
    chk("t6_busy_rst", {31'd0, busy}, 32'd0);
    chk("t6_enb_rst", {31'd0, enb}, 32'd0);
    q.delete();
    issued = 0;
    popped = 0;
    stall = 1'b0;
    @(posedge clk);
    #1;
    Reset = 1'b1;
    tready = 1'b1;
    d0 = done_cnt;
    start_row(1'b1);
    wait_done(d0 + 1, 60);
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
